// File: rtl/obj_ram_writer.sv
// -----------------------------------------------------------------------------
// obj_ram_writer
//
// Serialises the per-object state words produced by the game engine into a
// single object-RAM write port for the renderer.
//
// On every frame_tick the writer snapshots all object (addr, data) pairs into
// shadow registers. The renderer therefore sees one coherent object set per
// frame, even if the engine keeps updating its outputs. The shadowed slots
// are then written in order over a valid/ready port.
//
// Slot map: 0 = player tank, 1 = opponent tank, 2+k = bullet_*[k]
//           (bullets [0..MAX_BULLETS-1] belong to the player, the rest to
//           the opponent).
// Write address: {slot, entry addr}.
//
// Optional feature (macro SKIP_UNCHANGED_EN):
//   The writer remembers the last {addr, data} written to each slot, plus a
//   valid bit. A slot whose shadow pair matches that record is skipped. For
//   a skipped slot, wr_valid stays low for one cycle and then the pointer
//   advances, so with wr_ready=1 the frame length does not change.
//   When the macro is undefined, every slot is written every frame and no
//   history storage exists.
//
// Ports
//   clk          in   1            system clock
//   reset        in   1            asynchronous, active-low reset
//   frame_tick   in   1            1-cycle pulse at start of vertical blank
//   tank_addr    in   3            player tank entry address
//   tank_data    in   32           player tank state word
//   oppo_addr    in   3            opponent tank entry address
//   oppo_data    in   32           opponent tank state word
//   bullet_addr  in   2*MB x 3     bullet entry addresses
//   bullet_data  in   2*MB x 32    bullet state words
//   wr_valid     out  1            write request to object RAM
//   wr_ready     in   1            RAM accepts the write this cycle
//   wr_addr      out  SLOT_W+3     {slot, entry addr}
//   wr_data      out  32           state word
//   busy         out  1            snapshot/write sequence in progress
//   frame_done   out  1            1-cycle pulse after the last slot completes
//   overrun      out  1            sticky: frame_tick arrived while busy
// -----------------------------------------------------------------------------
module obj_ram_writer #(
  parameter int  MAX_BULLETS = 8,
  localparam int N_OBJ       = 2 + 2 * MAX_BULLETS,
  localparam int SLOT_W      = $clog2(N_OBJ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic [2:0]                      tank_addr,
  input  logic [31:0]                     tank_data,
  input  logic [2:0]                      oppo_addr,
  input  logic [31:0]                     oppo_data,
  input  logic [2*MAX_BULLETS-1:0][2:0]   bullet_addr,
  input  logic [2*MAX_BULLETS-1:0][31:0]  bullet_data,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [SLOT_W+2:0]               wr_addr,
  output logic [31:0]                     wr_data,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_OBJ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [SLOT_W-1:0]        ptr, ptr_nxt;

  // Shadow copy of the object set for the frame being written.
  logic [N_OBJ-1:0][2:0]    sh_addr;
  logic [N_OBJ-1:0][31:0]   sh_data;

  // Live inputs arranged in slot order. Packed concatenation puts the last
  // operand at index 0, which gives tank=0, oppo=1 and bullets from 2 up.
  logic [N_OBJ-1:0][2:0]    src_addr;
  logic [N_OBJ-1:0][31:0]   src_data;

  logic                     xfer;     // a write completes this cycle
  logic                     skip;     // current slot is unchanged and is skipped
  logic                     advance;  // current slot is finished this cycle

  assign src_addr = {bullet_addr, oppo_addr, tank_addr};
  assign src_data = {bullet_data, oppo_data, tank_data};

  // ---------------------------------------------------------------------------
  // Unchanged-slot suppression
  // ---------------------------------------------------------------------------
`ifdef SKIP_UNCHANGED_EN
  logic [N_OBJ-1:0]         lw_valid;
  logic [N_OBJ-1:0][34:0]   lw_pair;

  assign skip = (state == WRITE) && lw_valid[ptr] &&
                (lw_pair[ptr] == {sh_addr[ptr], sh_data[ptr]});

  // The history record is updated only by a completed transfer. A slot that
  // was stalled or interrupted by reset is therefore never treated as
  // already written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lw_valid <= '0;
    end else if (xfer) begin
      lw_valid[ptr] <= 1'b1;
    end
  end

  // The pair storage has no reset. Its contents are ignored until the
  // matching valid bit is set, so clearing the valid bits is enough.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lw_pair[ptr] <= {sh_addr[ptr], sh_data[ptr]};
    end
  end
`else
  assign skip = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output port
  // ---------------------------------------------------------------------------
  // The outputs are decoded directly from registered state. An asynchronous
  // reset therefore drops wr_valid immediately, with no clock edge.
  assign wr_valid   = (state == WRITE) && !skip;
  assign wr_addr    = {ptr, sh_addr[ptr]};
  assign wr_data    = sh_data[ptr];
  assign busy       = (state == LATCH) || (state == WRITE);
  assign frame_done = (state == DONE);

  assign xfer    = wr_valid && wr_ready;
  assign advance = (state == WRITE) && (xfer || skip);

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned. A path without an assignment would infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (frame_tick) state_nxt = LATCH;
      end
      LATCH: begin
        ptr_nxt   = '0;
        state_nxt = WRITE;
      end
      WRITE: begin
        // The pointer stops at the last slot. It never wraps inside a frame.
        if (advance) begin
          if (ptr == LAST_SLOT) state_nxt = DONE;
          else                  ptr_nxt   = ptr + SLOT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state and pointer registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from values sampled before the edge, whatever the order of
  // the always blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot registers
  // ---------------------------------------------------------------------------
  // NOTE: these storage arrays carry a reset, so wr_addr and wr_data read as
  // zero after reset. Wide stores that are never observed before they are
  // written (such as the history pairs) are left without a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_addr <= '0;
      sh_data <= '0;
    end else if (state == LATCH) begin
      sh_addr <= src_addr;
      sh_data <= src_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Overrun flag
  // ---------------------------------------------------------------------------
  // Any tick outside IDLE is dropped and flagged. This includes a tick that
  // arrives in the DONE cycle, since DONE is still part of the sequence. The
  // flag clears only on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (frame_tick && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obj_ram_writer.sv
// -----------------------------------------------------------------------------
// tb_obj_ram_writer
//
// Directed testbench for obj_ram_writer (MAX_BULLETS = 8, 18 slots).
// The bench drives and samples on the falling clock edge. Cycle 0 of a frame
// is the cycle in which frame_tick is high.
// -----------------------------------------------------------------------------
module tb_obj_ram_writer;

  localparam int MB    = 8;
  localparam int N_OBJ = 2 + 2 * MB;

`ifdef SKIP_UNCHANGED_EN
  localparam int T4_WRITES = 1;   // only the tank slot changed
`else
  localparam int T4_WRITES = N_OBJ;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  frame_tick;
  logic [2:0]            tank_addr, oppo_addr;
  logic [31:0]           tank_data, oppo_data;
  logic [2*MB-1:0][2:0]  bullet_addr;
  logic [2*MB-1:0][31:0] bullet_data;
  logic                  wr_valid, wr_ready;
  logic [7:0]            wr_addr;
  logic [31:0]           wr_data;
  logic                  busy, frame_done, overrun;

  obj_ram_writer #(.MAX_BULLETS(MB)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .tank_addr   (tank_addr),
    .tank_data   (tank_data),
    .oppo_addr   (oppo_addr),
    .oppo_data   (oppo_data),
    .bullet_addr (bullet_addr),
    .bullet_data (bullet_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;

  // Log of one frame's completed writes.
  logic [7:0]  wa [64];
  logic [31:0] wd [64];
  int          wrel [64];
  int          n_wr;
  int          done_rel;
  logic [39:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_addr(input int i);
    logic [2:0] a;
    if (i == 0)      a = tank_addr;
    else if (i == 1) a = oppo_addr;
    else             a = bullet_addr[i-2];
    return {i[4:0], a};
  endfunction

  function automatic logic [31:0] exp_data(input int i);
    if (i == 0)      return tank_data;
    else if (i == 1) return oppo_data;
    else             return bullet_data[i-2];
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b0;
    frame_tick = 1'b0;
    wr_ready   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one frame: pulses frame_tick, then logs writes until frame_done or
  // the cycle budget runs out.
  //   stall_slot/stall_len : hold wr_ready low for stall_len cycles at that slot
  //   chg_rel/chg_val      : change tank_data in that cycle
  //   tick2_rel            : extra frame_tick in that cycle
  //   rst_slot             : assert reset when this slot is presented
  task automatic run_frame(input int stall_slot, input int stall_len,
                           input int chg_rel, input logic [31:0] chg_val,
                           input int tick2_rel, input int rst_slot);
    int stalled;
    n_wr     = 0;
    done_rel = -1;
    stalled  = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    wr_ready   = 1'b1;
    for (int rel = 1; rel <= 60; rel++) begin
      @(negedge clk);
      frame_tick = (rel == tick2_rel);
      if (rel == chg_rel) tank_data = chg_val;
      if (rel == 1) begin
        check("latch_busy", 64'(busy), 64'd1);
        check("latch_valid", 64'(wr_valid), 64'd0);
      end
      if (frame_done) begin
        done_rel = rel;
        break;
      end
      wr_ready = 1'b1;
      if (wr_valid) begin
        if (rst_slot >= 0 && int'(wr_addr[7:3]) == rst_slot) begin
          reset = 1'b0;
          #1;
          check("rst_async_valid", 64'(wr_valid), 64'd0);
          check("rst_async_busy", 64'(busy), 64'd0);
          check("rst_async_addr", 64'(wr_addr), 64'd0);
          break;
        end
        if (int'(wr_addr[7:3]) == stall_slot && stalled < stall_len) begin
          if (stalled == 0) held = {wr_addr, wr_data};
          else              check("stall_hold", 64'({wr_addr, wr_data}), 64'(held));
          stalled++;
          wr_ready = 1'b0;
        end else begin
          wa[n_wr]   = wr_addr;
          wd[n_wr]   = wr_data;
          wrel[n_wr] = rel;
          n_wr++;
        end
      end
    end
    @(negedge clk);
    frame_tick = 1'b0;
    wr_ready   = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    frame_tick  = 1'b0;
    wr_ready    = 1'b1;
    tank_addr   = 3'd2;
    tank_data   = 32'hA5A5_0001;
    oppo_addr   = 3'd5;
    oppo_data   = 32'h0BB0_0002;
    for (int k = 0; k < 2*MB; k++) begin
      bullet_addr[k] = 3'(k);
      bullet_data[k] = 32'hB000_0000 | 32'(k);
    end

    // ---- Reset values ----
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // ---- 1: basic frame, wr_ready tied high ----
    run_frame(-1, 0, -1, 32'h0, -1, -1);
    check("t1_n_writes", 64'(n_wr), 64'd18);
    check("t1_first_rel", 64'(wrel[0]), 64'd2);
    check("t1_first_addr", 64'(wa[0]), 64'h02);
    check("t1_first_data", 64'(wd[0]), 64'hA5A5_0001);
    check("t1_done_rel", 64'(done_rel), 64'd20);
    for (int i = 0; i < N_OBJ; i++) begin
      check("t1_slot_addr", 64'(wa[i]), 64'(exp_addr(i)));
      check("t1_slot_data", 64'(wd[i]), 64'(exp_data(i)));
    end
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_overrun", 64'(overrun), 64'd0);

    // ---- 2: stall 5 cycles at slot 4 ----
    apply_reset();
    run_frame(4, 5, -1, 32'h0, -1, -1);
    check("t2_n_writes", 64'(n_wr), 64'd18);
    check("t2_done_rel", 64'(done_rel), 64'd25);
    check("t2_slot4_after_stall", 64'({wa[4], wd[4]}), 64'(held));
    check("t2_slot4_rel", 64'(wrel[4]), 64'd11);
    for (int i = 0; i < N_OBJ; i++)
      check("t2_slot_order", 64'(wa[i][7:3]), 64'(i));

    // ---- 3: tank_data changes mid-frame ----
    apply_reset();
    run_frame(-1, 0, 3, 32'h0000_1234, -1, -1);
    check("t3_snapshot_data", 64'(wd[0]), 64'hA5A5_0001);
    check("t3_n_writes", 64'(n_wr), 64'd18);

    // ---- 4: second frame_tick at cycle 6 of the next frame ----
    run_frame(-1, 0, -1, 32'h0, 6, -1);
    check("t4_new_data", 64'(wd[0]), 64'h0000_1234);
    check("t4_addr", 64'(wa[0]), 64'h02);
    check("t4_n_writes", 64'(n_wr), 64'(T4_WRITES));
    check("t4_done_rel", 64'(done_rel), 64'd20);
    check("t4_overrun", 64'(overrun), 64'd1);
    repeat (5) @(negedge clk);
    check("t4_overrun_sticky", 64'(overrun), 64'd1);
    check("t4_idle_busy", 64'(busy), 64'd0);
    tank_data = 32'hA5A5_0001;

    // ---- 5: reset asserted at slot 9 ----
    apply_reset();
    check("t5_overrun_cleared", 64'(overrun), 64'd0);
    run_frame(-1, 0, -1, 32'h0, -1, 9);
    check("t5_partial_writes", 64'(n_wr), 64'd9);
    reset = 1'b1;
    @(negedge clk);
    check("t5_idle_valid", 64'(wr_valid), 64'd0);
    run_frame(-1, 0, -1, 32'h0, -1, -1);
    check("t5_restart_slot", 64'(wa[0]), 64'h02);
    check("t5_restart_rel", 64'(wrel[0]), 64'd2);
    check("t5_restart_writes", 64'(n_wr), 64'd18);
    check("t5_restart_done", 64'(done_rel), 64'd20);
    check("t5_overrun", 64'(overrun), 64'd0);

    // ---- frame_tick during the DONE cycle is ignored and flagged ----
    run_frame(-1, 0, -1, 32'h0, 20, -1);
    check("done_tick_done_rel", 64'(done_rel), 64'd20);
    check("done_tick_overrun", 64'(overrun), 64'd1);
    check("done_tick_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_tick_no_restart", 64'(busy), 64'd0);

`ifdef SKIP_UNCHANGED_EN
    // ---- 6: identical frames except bullet 3 ----
    apply_reset();
    run_frame(-1, 0, -1, 32'h0, -1, -1);
    check("t6_f1_writes", 64'(n_wr), 64'd18);
    bullet_data[3] = 32'hDEAD_0003;
    run_frame(-1, 0, -1, 32'h0, -1, -1);
    check("t6_f2_writes", 64'(n_wr), 64'd1);
    check("t6_f2_addr", 64'(wa[0]), 64'h2B);
    check("t6_f2_data", 64'(wd[0]), 64'hDEAD_0003);
    check("t6_f2_done", 64'(done_rel), 64'd20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
